// File: rtl/ysyx_220066_pkg.sv
// Shared encodings for the store unit: MemOp size field and FSM state.
package ysyx_220066_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/ysyx_220066_store_align.sv
// Lane replication, byte-enable mask and misalignment detection for one store.
module ysyx_220066_store_align
  import ysyx_220066_pkg::*;
(
  input  logic [2:0]  addr_lo_i,
  input  logic [63:0] data_i,
  input  mem_size_e   size_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wmask_o,
  output logic        misalign_o
);

  always_comb begin
    wdata_o    = data_i;
    wmask_o    = 8'hFF;
    misalign_o = 1'b0;
    unique case (size_i)
      SZ_B: begin
        wdata_o = {8{data_i[7:0]}};
        wmask_o = 8'h01 << addr_lo_i;
      end
      SZ_H: begin
        wdata_o    = {4{data_i[15:0]}};
        wmask_o    = 8'h03 << addr_lo_i;
        misalign_o = addr_lo_i[0];
      end
      SZ_W: begin
        wdata_o    = {2{data_i[31:0]}};
        wmask_o    = 8'h0F << addr_lo_i;
        misalign_o = (addr_lo_i[1:0] != 2'b00);
      end
      SZ_D: begin
        wdata_o    = data_i;
        wmask_o    = 8'hFF;
        misalign_o = (addr_lo_i != 3'b000);
      end
      default: begin
        wdata_o    = data_i;
        wmask_o    = 8'hFF;
        misalign_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_220066_mem_store.sv
// Store unit: accepts one store, issues a single memory write with timeout,
// and reports completion/error with a one-cycle done pulse.
module ysyx_220066_mem_store
  import ysyx_220066_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_data,
  input  logic [2:0]  in_MemOp,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic        done,
  output logic        error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       wmask_q;
  logic [63:3]      addr_q;
  logic [63:0]      wdata_q;

  logic [63:0]      al_wdata;
  logic [7:0]       al_wmask;
  logic             al_misalign;
  logic             accept;
  logic             unused_memop_hi;

  assign unused_memop_hi = in_MemOp[2];

  // Alignment is evaluated on the incoming request and captured at acceptance,
  // so the memory-side outputs are plain registers and stay stable in REQ.
  ysyx_220066_store_align u_align (
    .addr_lo_i  (in_addr[2:0]),
    .data_i     (in_data),
    .size_i     (mem_size_e'(in_MemOp[1:0])),
    .wdata_o    (al_wdata),
    .wmask_o    (al_wmask),
    .misalign_o (al_misalign)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) wmask_q <= al_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= in_addr[63:3];
      wdata_q <= al_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (al_misalign) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
            err_d   = 1'b0;
          end
        end
      end
      ST_REQ: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (mem_ack) begin
          state_d = ST_RESP;
          err_d   = mem_err;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_addr  = {addr_q, 3'b000};
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign done      = (state_q == ST_RESP);
  assign error     = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_ysyx_220066_mem_store.sv
// Scoreboard bench for the store unit: the driver queues expected transactions,
// a negedge monitor checks the memory side and the done/error response.
module tb_ysyx_220066_mem_store;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_addr = '0;
  logic [63:0] in_data = '0;
  logic [2:0]  in_MemOp = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        mis;
    int          req;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  ysyx_220066_mem_store #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_MemOp  (in_MemOp),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor
  int   req_cnt  = 0;
  int   last_req = 0;
  int   acc_cyc  = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      req_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", {63'd0, done}, 64'd0);
      if (in_valid && in_ready) acc_cyc = cyc;
      if (mem_req) begin
        if (exp_q.size() == 0) flag_fail("unexpected_mem_req");
        else begin
          check("mem_addr",  mem_addr,  exp_q[0].addr);
          check("mem_wdata", mem_wdata, exp_q[0].wdata);
          check("mem_wmask", {56'd0, mem_wmask}, {56'd0, exp_q[0].wmask});
        end
        req_cnt++;
        last_req = cyc;
      end
      if (done) begin
        if (exp_q.size() == 0) flag_fail("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("error", {63'd0, error}, {63'd0, e.err});
          check("req_cycles", 64'(req_cnt), 64'(e.req));
          check("done_latency", 64'(cyc), e.mis ? 64'(acc_cyc + 1) : 64'(last_req + 1));
        end
        req_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic wait_done();
    int i;
    for (i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
    end
    if (!done) flag_fail("done_timeout");
  endtask

  // dly: cycles after mem_req rises before mem_ack; negative means never ack.
  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] op,
                       input int dly, input logic berr,
                       input logic [63:0] ea, input logic [63:0] ew, input logic [7:0] em,
                       input logic mis, input int rq, input logic eerr);
    exp_t e;
    e.addr = ea; e.wdata = ew; e.wmask = em; e.mis = mis; e.req = rq; e.err = eerr;
    @(posedge clk); #1;
    exp_q.push_back(e);
    in_valid = 1'b1; in_addr = a; in_data = d; in_MemOp = op;
    @(posedge clk); #1;
    in_valid = 1'b0; in_addr = ~a; in_data = ~d; in_MemOp = 3'b011;
    if (dly >= 0) begin
      repeat (dly) begin @(posedge clk); #1; end
      mem_ack = 1'b1; mem_err = berr;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_err = 1'b0;
    end
    wait_done();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #12;
    check("rst_mem_req",   {63'd0, mem_req}, 64'd0);
    check("rst_done",      {63'd0, done}, 64'd0);
    check("rst_error",     {63'd0, error}, 64'd0);
    check("rst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // sb with ack two cycles after mem_req rises
    store(64'h1003, 64'hAB, 3'b000, 2, 1'b0,
          64'h1000, 64'hABABABABABABABAB, 8'h08, 1'b0, 3, 1'b0);
    // sh with immediate ack
    store(64'h1006, 64'h1234, 3'b001, 0, 1'b0,
          64'h1000, 64'h1234123412341234, 8'hC0, 1'b0, 1, 1'b0);
    // sw misaligned
    store(64'h1002, 64'hCAFEF00D, 3'b010, -1, 1'b0,
          64'h1000, 64'h0, 8'h00, 1'b1, 0, 1'b1);
    // sd with no ack: timeout after four request cycles
    store(64'h1008, 64'h0123456789ABCDEF, 3'b011, -1, 1'b0,
          64'h1008, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 4, 1'b1);
    // sw upper lane, bus error on ack
    store(64'h2004, 64'hDEADBEEF, 3'b010, 1, 1'b1,
          64'h2000, 64'hDEADBEEFDEADBEEF, 8'hF0, 1'b0, 2, 1'b1);
    // sh with MemOp[2] set, ack in the timeout cycle without error
    store(64'h3002, 64'hFFFF5A5A, 3'b101, 3, 1'b0,
          64'h3000, 64'h5A5A5A5A5A5A5A5A, 8'h0C, 1'b0, 4, 1'b0);
    // sh and sd misaligned
    store(64'h1001, 64'h1, 3'b001, -1, 1'b0, 64'h1000, 64'h0, 8'h00, 1'b1, 0, 1'b1);
    store(64'h1004, 64'h1, 3'b011, -1, 1'b0, 64'h1000, 64'h0, 8'h00, 1'b1, 0, 1'b1);
    // sb picks the low byte only
    store(64'h6005, 64'h1122334455667788, 3'b000, 0, 1'b0,
          64'h6000, 64'h8888888888888888, 8'h20, 1'b0, 1, 1'b0);

    // ack/err while idle must be ignored
    mem_ack = 1'b1; mem_err = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_err = 1'b0;
    @(posedge clk); #1;
    check("idle_ack_done",  {63'd0, done}, 64'd0);
    check("idle_ack_ready", {63'd0, in_ready}, 64'd1);

    // reset in the middle of REQ
    e.addr = 64'h4000; e.wdata = 64'h0123456789ABCDEF; e.wmask = 8'hFF;
    e.mis = 1'b0; e.req = 0; e.err = 1'b0;
    exp_q.push_back(e);
    in_valid = 1'b1; in_addr = 64'h4000; in_data = 64'h0123456789ABCDEF; in_MemOp = 3'b011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("async_rst_done",    {63'd0, done}, 64'd0);
    check("async_rst_wmask",   {56'd0, mem_wmask}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("ready_after_rel", {63'd0, in_ready}, 64'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("no_done_after_rst", {63'd0, done}, 64'd0);

    store(64'h5000, 64'h77, 3'b000, 0, 1'b0,
          64'h5000, 64'h7777777777777777, 8'h01, 1'b0, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_mem_store.md
YSYX_220066_MEM_STORE -- requirements
Module: ysyx_220066_mem_store

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, range 1..255: maximum cycles mem_req is held waiting for mem_ack.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  store request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port in_addr  input  64  byte address of the store.
REQ-007 SHALL have port in_data  input  64  store data, right-aligned.
REQ-008 SHALL have port in_MemOp  input  3  size in [1:0]: 00 byte, 01 half, 10 word, 11 double; [2] ignored.
REQ-009 SHALL have port mem_req  output  1  memory write request.
REQ-010 SHALL have port mem_addr  output  64  in_addr with bits [2:0] cleared.
REQ-011 SHALL have port mem_wdata  output  64  lane-replicated write data.
REQ-012 SHALL have port mem_wmask  output  8  byte-enable mask.
REQ-013 SHALL have port mem_ack  input  1  memory accepted/completed the write.
REQ-014 SHALL have port mem_err  input  1  bus error; sampled only with mem_ack.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port error  output  1  store failed; meaningful only while done=1.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP.
REQ-018 SHALL assert in_ready only in IDLE; accept on in_valid && in_ready.
REQ-019 SHALL register addr, data and size on acceptance; later input changes have no effect.
REQ-020 SHALL compute lane/mask from addr[2:0] = a: byte -> wdata {8{d[7:0]}}, mask 8'h01<<a; half -> {4{d[15:0]}}, 8'h03<<a; word -> {2{d[31:0]}}, 8'h0F<<a; double -> d, 8'hFF.
REQ-021 SHALL flag misaligned when half has a[0]=1, word has a[1:0]!=0, or double has a!=0.
REQ-022 SHALL on aligned acceptance go to REQ; mem_req=1 in the first cycle after acceptance.
REQ-023 SHALL on misaligned acceptance go to RESP without ever asserting mem_req; error=1.
REQ-024 SHALL hold mem_req, mem_addr, mem_wdata and mem_wmask stable throughout REQ.
REQ-025 SHALL in REQ on mem_ack go to RESP with error=mem_err.
REQ-026 SHALL in REQ use an 8-bit wait counter, cleared on entry to REQ. If count==TIMEOUT-1 and no ack, go to RESP with error=1, so mem_req is high exactly TIMEOUT cycles.
REQ-027 SHALL give mem_ack priority over timeout in the same cycle.
REQ-028 SHALL ignore mem_ack and mem_err outside REQ.
REQ-029 SHALL assert done for exactly one cycle in RESP, then return to IDLE.
REQ-030 SHALL drive mem_req=0, done=0 and error=0 in IDLE.
REQ-031 SHALL have latency ack-cycle+1 to done; misaligned: accept-cycle+1 to done.

Reset
REQ-032 SHALL on rst=0 immediately (asynchronously) force state IDLE, counter 0, mem_req 0, done 0, error 0, mem_wmask 0; in_ready=1 after rst returns high.
REQ-033 SHALL abandon any in-flight store on reset mid-REQ, with no done pulse.

Structure
REQ-034 SHALL take MemOp size encodings and FSM state encoding from shared package ysyx_220066_pkg.
REQ-035 SHALL place lane replication, mask and misalign logic in one combinational sub-module, ysyx_220066_store_align; FSM, counter and registers stay in the top module.

Verification
REQ-036 SHALL cover: sb, addr 0x1003, data 0xAB, ack 2 cycles after mem_req rises -> mem_addr 0x1000, mask 0x08, wdata 0xABABABABABABABAB; done one cycle after ack; error=0.
REQ-037 SHALL cover: sh, addr 0x1006, data 0x1234 -> mask 0xC0, wdata 0x1234123412341234.
REQ-038 SHALL cover: sw, addr 0x1002 -> mem_req never asserted; done in the cycle after accept; error=1.
REQ-039 SHALL cover: sd, addr 0x1008, TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then done with error=1.
REQ-040 SHALL cover: ack with mem_err=1 -> done with error=1; ack coincident with the timeout cycle and mem_err=0 -> error=0.
REQ-041 SHALL cover: rst low during REQ -> mem_req 0 without waiting for a clock edge; no done; in_ready=1 after release; next store completes normally.
